// File: rtl/rca32_share_arb.sv
// Round-robin share of one 32-bit ripple-carry adder among NREQ valid/ready requesters.
// Latency: 1 cycle from acceptance to rsp_valid; 1 op/cycle while rsp_ready is held high.
// Backpressure: req_ready drops for everyone while a result is held and rsp_ready is low.

// Plain 32-bit ripple-carry adder: one full-adder cell per bit, carry rippling upward.
module d_rca32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [32:0] w_c;

    assign w_c[0] = i_cin;

    // One full-adder per bit position.
    for (genvar g = 0; g < 32; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[32];
endmodule

module rca32_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [32*NREQ-1:0]   i_req_a,
    input  logic [32*NREQ-1:0]   i_req_b,
    input  logic [NREQ-1:0]      i_req_cin,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_sum,
    output logic                 o_rsp_cout,
    output logic [IDW-1:0]       o_rsp_id
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_prio;
    logic [31:0]     r_sum;
    logic            r_cout;
    logic [IDW-1:0]  r_id;

    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic            w_can_accept;
    logic            w_accept;
    logic [IDW-1:0]  w_prio_nxt;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic            w_cin;
    logic [31:0]     w_sum;
    logic            w_cout;

    // Round-robin search: requester i sits at offset k from prio when prio == (i-k) mod NREQ.
    // Offsets are walked from farthest to nearest so the nearest valid requester wins last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i_req_valid[i] && (r_prio == IDW'((i - k + NREQ) % NREQ))) begin
                    w_any = 1'b1;
                    w_win = IDW'(i);
                end
            end
        end
    end

    // Output slot is free when empty, or when the held result leaves on this edge.
    assign w_can_accept = (r_state == EMPTY) | i_rsp_ready;
    assign w_accept     = w_any & w_can_accept & i_rst_n;
    assign w_prio_nxt   = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

    // One-hot ready to the winner only; forced low while reset is asserted.
    always_comb begin
        o_req_ready = '0;
        if (w_accept) begin
            o_req_ready[w_win] = 1'b1;
        end
    end

    // Operand mux from the winner's slice.
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_a   = i_req_a[32*i +: 32];
                w_b   = i_req_b[32*i +: 32];
                w_cin = i_req_cin[i];
            end
        end
    end

    d_rca32 u_rca (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Result-register FSM: load on accept (drain and reload share one edge), empty on bare drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EMPTY;
            r_prio  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= FULL;
                        r_prio  <= w_prio_nxt;
                        r_sum   <= w_sum;
                        r_cout  <= w_cout;
                        r_id    <= w_win;
                    end
                end
                FULL: begin
                    if (w_accept) begin
                        r_state <= FULL;
                        r_prio  <= w_prio_nxt;
                        r_sum   <= w_sum;
                        r_cout  <= w_cout;
                        r_id    <= w_win;
                    end else if (i_rsp_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign o_rsp_valid = (r_state == FULL);
    assign o_rsp_sum   = r_sum;
    assign o_rsp_cout  = r_cout;
    assign o_rsp_id    = r_id;
endmodule

// File: tb/tb_rca32_share_arb.sv
// Scoreboarded directed bench for rca32_share_arb (NREQ=4).
// Expected results come from a hand-computed per-requester table.
// A negedge monitor pops and compares every consumed response.

module tb_rca32_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_sum;
    logic               rsp_cout;
    logic [IDW-1:0]     rsp_id;

    rca32_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_cin   (req_cin),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout),
        .o_rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed results for each requester's fixed operands.
    //  r0: 0x00000005 + 0x00000003 + 0 = 0x00000008 cout 0
    //  r1: 0x7FFFFFFF + 0x00000001 + 1 = 0x80000001 cout 0
    //  r2: 0xFFFFFFFF + 0x00000001 + 0 = 0x00000000 cout 1
    //  r3: 0x80000000 + 0x80000000 + 1 = 0x00000001 cout 1
    logic [31:0] va   [NREQ] = '{32'h0000_0005, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vb   [NREQ] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    logic        vc   [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] esum [NREQ] = '{32'h0000_0008, 32'h8000_0001, 32'h0000_0000, 32'h0000_0001};
    logic        ecout[NREQ] = '{1'b0, 1'b0, 1'b1, 1'b1};

    logic [34:0] sb_q[$];
    int          nchk = 0;
    int          nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] oh);
        int r = 0;
        for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // One cycle: check the grant before the edge, record the expected result, then advance.
    task automatic cyc(input logic [NREQ-1:0] exp_rdy, input string name);
        int w;
        @(negedge clk);
        chk(name, {60'd0, req_ready}, {60'd0, exp_rdy});
        if (exp_rdy != '0) begin
            w = oh2i(exp_rdy);
            sb_q.push_back({esum[w], ecout[w], IDW'(w)});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result consumed at the coming edge must match the scoreboard head.
    always @(negedge clk) begin
        logic [34:0] e;
        if (rst_n && rsp_valid && rsp_ready) begin
            nchk++;
            if (sb_q.size() == 0) begin
                nerr++;
                $display("FAIL rsp_unexpected: got sum=0x%h cout=%0d id=%0d with empty scoreboard",
                         rsp_sum, rsp_cout, rsp_id);
            end else begin
                e = sb_q.pop_front();
                if ({rsp_sum, rsp_cout, rsp_id} !== e) begin
                    nerr++;
                    $display("FAIL rsp_data: got sum=0x%h cout=%0d id=%0d expected sum=0x%h cout=%0d id=%0d",
                             rsp_sum, rsp_cout, rsp_id, e[34:3], e[2], e[1:0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = va[i];
            req_b[32*i +: 32] = vb[i];
            req_cin[i]        = vc[i];
        end
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;

        // Reset state, with requests present.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_sum",   {32'd0, rsp_sum},   64'd0);
        chk("rst_cout",  {63'd0, rsp_cout},  64'd0);
        chk("rst_id",    {62'd0, rsp_id},    64'd0);
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;

        // Single requester 2: wrap to zero with carry out.
        req_valid = 4'b0100;
        cyc(4'b0100, "r2_grant");
        req_valid = 4'b0000;
        chk("r2_valid", {63'd0, rsp_valid}, 64'd1);
        chk("r2_sum",   {32'd0, rsp_sum},   64'd0);
        chk("r2_cout",  {63'd0, rsp_cout},  64'd1);
        chk("r2_id",    {62'd0, rsp_id},    64'd2);

        // Backpressure: held result, requesters 0 and 3 waiting.
        req_valid = 4'b1001;
        for (int n = 0; n < 5; n++) begin
            cyc(4'b0000, "bp_ready_low");
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_stable", {29'd0, rsp_sum, rsp_cout, rsp_id}, {29'd0, 32'h0, 1'b1, 2'd2});
        end
        // Release: prio is 3 after granting 2, so 3 wins and loads as 2 drains.
        rsp_ready = 1'b1;
        cyc(4'b1000, "bp_release_r3");
        chk("bp_reload_id", {62'd0, rsp_id}, 64'd3);
        req_valid = 4'b0001;
        cyc(4'b0001, "after_r3_r0");
        req_valid = 4'b0000;

        // Drain to empty: register contents hold.
        cyc(4'b0000, "drain_no_grant");
        chk("drain_valid", {63'd0, rsp_valid}, 64'd0);
        chk("drain_sum",   {32'd0, rsp_sum},   64'h8);
        chk("drain_id",    {62'd0, rsp_id},    64'd0);

        // Reset with a held result discards it.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        cyc(4'b0010, "pre_rst_r1");
        chk("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
        req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_sum",   {32'd0, rsp_sum},   64'd0);
        chk("mid_rst_cout",  {63'd0, rsp_cout},  64'd0);
        chk("mid_rst_id",    {62'd0, rsp_id},    64'd0);
        req_valid = 4'b1111;
        chk("mid_rst_ready", {60'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // All four valid: back-to-back grants 0,1,2,3,0.
        cyc(4'b0001, "rr_g0");
        cyc(4'b0010, "rr_g1");
        cyc(4'b0100, "rr_g2");
        cyc(4'b1000, "rr_g3");
        cyc(4'b0001, "rr_g0b");

        // Fairness after a skip: prio=1, only 0 and 3 valid -> 3 then 0.
        req_valid = 4'b1001;
        cyc(4'b1000, "skip_g3");
        req_valid = 4'b0001;
        cyc(4'b0001, "skip_g0");
        req_valid = 4'b0000;
        cyc(4'b0000, "final_drain");
        cyc(4'b0000, "final_idle");
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/rca32_share_arb.md
# rca32_share_arb

Round-robin arbiter that shares one 32-bit ripple-carry adder (`d_rca32`, instantiated internally) among `NREQ` independent requesters. Each requester presents an add operation (a, b, cin) over a valid/ready handshake. The granted operation passes through the adder, and the result is captured in a single output register with valid/ready backpressure, tagged with the requester index. The block sits between several datapath clients and the single shared adder resource, so that a dedicated adder per client is not needed.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default 2: width of the requester-index tag; must equal ceil(log2(NREQ)).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: bit i set when requester i presents an operation.
- `req_ready`  out  NREQ: bit i set when requester i's operation is accepted this cycle; one-hot or zero.
- `req_a`  in  32*NREQ: operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NREQ: operand B, packed the same way as `req_a`.
- `req_cin`  in  NREQ: carry-in per requester.
- `rsp_valid`  out  1: result register holds a result.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_sum`  out  32: registered sum.
- `rsp_cout`  out  1: registered carry-out.
- `rsp_id`  out  IDW: index of the requester that produced the result.

## Operation
- FSM with two states:
  - EMPTY: the output register is free.
  - FULL: the output register holds a result that has not yet been consumed.
- `can_accept` = (state == EMPTY) | (state == FULL & rsp_ready).
- Arbitration is combinational and round-robin:
  - The pointer `prio` (IDW bits) marks the highest-priority index.
  - Search order is prio, prio+1, …, NREQ-1, 0, …, prio-1.
  - The first requester in that order with `req_valid` set wins.
- `req_ready[w]` = `can_accept` for the winner w; all other bits are 0.
- `req_ready` never depends on `rsp_valid` for non-winners, and never rises for a requester whose `req_valid` is low.
- Adder inputs are muxed from the winner's slice. Outputs go straight to the output register: no carry/sum modification, with modulo-2^32 wrap and cout as produced by the adder.
- On acceptance of winner w:
  - Load `rsp_sum`, `rsp_cout`, and `rsp_id`=w.
  - Set `prio` = (w+1) mod NREQ.
  - Next state is FULL.
- Drain without a new acceptance (FULL & `rsp_ready` & no valid request): next state is EMPTY and the register contents hold.
- Simultaneous drain and accept in FULL: the old result leaves and the new result loads in the same edge. The state stays FULL with no bubble.
- With no grant, `prio` is unchanged.
- `rsp_sum`, `rsp_cout`, and `rsp_id` stay stable while `rsp_valid` is 1 and `rsp_ready` is 0.
- Fairness: any requester holding `req_valid` is granted within NREQ acceptances.
- Requesters must hold their operands and `req_valid` until they see `req_ready`. The block does not check this.

## Timing
- Reset values (async assert, synchronous-release behaviour is the environment's job):
  - state = EMPTY, `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_id` = 0, `prio` = 0.
  - `req_ready` reads 0 while `rst_n` is low.
- Reset mid-operation discards any held result with no response; the first edge after release behaves as EMPTY.
- Latency is 1 cycle: an operation accepted at edge k has `rsp_valid` = 1 after edge k.
- Throughput is 1 operation per cycle while `rsp_ready` is held high.
- `req_ready` is combinational from `req_valid`, `prio`, state and `rsp_ready`.
- `rsp_*` are registered with no combinational path from the inputs.
- The critical path is arbiter, then operand mux, then the 32-bit ripple chain, then the output register. Synthesis budgets the full period for it.

## Test plan
- Reset with a result held: `rsp_valid` = 1, then `rst_n` = 0 → all `rsp_*` = 0 immediately, and after release `req_ready` goes high for the first valid requester.
- Single requester 2: a=0xFFFFFFFF, b=0x00000001, cin=0 → the next cycle gives `rsp_sum` = 0x00000000, `rsp_cout` = 1, `rsp_id` = 2, and `prio` becomes 3.
- All four valid continuously with `rsp_ready` = 1, starting from reset → grants in order 0,1,2,3,0 on consecutive cycles with no bubble. Each result matches a+b+cin of the matching requester (e.g. requester 1: 0x7FFFFFFF + 0x1 + 1 = 0x80000001, cout 0).
- Backpressure: result held with `rsp_ready` = 0 for 5 cycles while requesters 0 and 3 are valid → `req_ready` = 0 throughout and `rsp_*` stable. `rsp_ready` = 1 → the held result drains and the next winner loads on the same edge.
- Fairness after a skip: `prio` = 1 with only requesters 0 and 3 valid → 3 wins first, then 0; `prio` sequence is 0 then 1.
- Drain to empty: FULL, `rsp_ready` = 1, no `req_valid` → `rsp_valid` = 0 the next cycle, and the sum/id registers keep their last values.
